// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_queue_pkg;

    localparam int              XLEN         = 32;
    localparam logic [XLEN-1:0] INST_NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Register-based FIFO with occupancy count and a synchronous flush.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rptr];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only accepted when a pop frees the slot.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: sequential fetch with credit limits, in-order pc tags,
// decode-side FIFO, and redirect flush that kills in-flight responses.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst
);

    localparam int CW = $clog2(DEPTH) + 2;
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [XLEN-1:0]       fetch_pc;
    logic [CW-1:0]         live_cnt, kill_cnt, kill_sum, kill_redir;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic                  fifo_empty, fifo_full_unused;
    logic [1:0]            redir_lsb_unused;
    logic                  rsp_kill, rsp_live, fifo_push, fifo_pop;
    logic [XLEN-1:0]       tag_q [MAX_OUT];
    logic [TW-1:0]         tag_wp, tag_rp;
    fetch_entry_t          push_ent, head, hold_q;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign redir_lsb_unused = redirect_pc[1:0];
    assign imem_addr        = fetch_pc;
    // Gated by reset so no request is seen while the block is held in reset.
    assign imem_req = rst && !redirect_valid
                   && ((CW'(fifo_cnt) + live_cnt) < CW'(DEPTH))
                   && ((live_cnt + kill_cnt) < CW'(MAX_OUT));

    assign rsp_kill  = imem_rvalid && (kill_cnt != '0);
    assign rsp_live  = imem_rvalid && (kill_cnt == '0) && (live_cnt != '0);
    assign fifo_push = rsp_live && !redirect_valid;
    assign fifo_pop  = out_valid && out_ready;
    assign push_ent  = '{pc: tag_q[tag_rp], inst: imem_rdata};

    always_comb begin
        kill_sum   = kill_cnt + live_cnt;
        kill_redir = kill_sum;
        if (imem_rvalid && (kill_sum != '0)) kill_redir = kill_sum - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            live_cnt <= '0;
            kill_cnt <= '0;
            tag_wp   <= '0;
            tag_rp   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            live_cnt <= '0;
            kill_cnt <= kill_redir;
            tag_wp   <= '0;
            tag_rp   <= '0;
        end else begin
            if (imem_req) begin
                fetch_pc <= fetch_pc + 32'd4;
                tag_wp   <= tag_inc(tag_wp);
            end
            if (rsp_live) tag_rp <= tag_inc(tag_rp);
            live_cnt <= live_cnt + CW'(imem_req) - CW'(rsp_live);
            kill_cnt <= kill_cnt - CW'(rsp_kill);
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) tag_q[tag_wp] <= fetch_pc;
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (push_ent),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .dout  (head),
        .full  (fifo_full_unused),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // Remembers the last visible head so outputs hold while the FIFO is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           hold_q <= '0;
        else if (out_valid) hold_q <= head;
    end

    assign out_valid = !fifo_empty;
    assign out_pc    = out_valid ? head.pc   : hold_q.pc;
    assign out_inst  = out_valid ? head.inst : hold_q.inst;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a small in-order instruction memory model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_inst;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] pend [$];
    logic        mem_en = 1'b0;
    logic        chk_addr = 1'b0, chk_out = 1'b0;
    logic [31:0] exp_addr = '0, exp_pc = '0;

    fetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sample at the falling edge, then advance one rising edge and drive memory.
    task automatic tick();
        logic rq, rv;
        logic [31:0] ad;
        @(negedge clk);
        rq = imem_req; ad = imem_addr; rv = imem_rvalid;
        if (chk_addr && rq) begin
            chk("addr_seq", ad, exp_addr);
            exp_addr += 32'd4;
        end
        if (chk_out && out_valid && out_ready) begin
            chk("pop_pc", out_pc, exp_pc);
            chk("pop_inst", out_inst, inst_of(exp_pc));
            exp_pc += 32'd4;
        end
        @(posedge clk);
        #1;
        if (rv && pend.size() > 0) pend.delete(0);
        if (rq) pend.push_back(ad);
        if (mem_en && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = inst_of(pend[0]);
        end else begin
            imem_rvalid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        imem_rvalid = 1'b0;
        pend.delete();
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!out_valid && n < max) begin
            tick();
            n++;
        end
        chk("wait_valid", {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        mem_en = 1'b1;
        #1;
        chk("rel_req", {31'b0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0);

        // Streaming, one instruction per cycle
        chk_addr = 1'b1; exp_addr = 32'h0;
        chk_out  = 1'b1; exp_pc   = 32'h0;
        tick();
        chk("lat_valid_n1", {31'b0, out_valid}, 32'd0);
        tick();
        chk("lat_valid_n2", {31'b0, out_valid}, 32'd1);
        chk("lat_pc", out_pc, 32'h0);
        repeat (4) tick();
        chk("stream_cnt", exp_pc, 32'h10);

        // Back-pressure: queue fills, fetch stops at the credit limit
        out_ready = 1'b0;
        repeat (10) tick();
        chk("bp_req", {31'b0, imem_req}, 32'd0);
        chk("bp_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_head", out_pc, 32'h10);
        chk("bp_issued", exp_addr, 32'h20);
        out_ready = 1'b1;
        repeat (8) tick();
        chk("bp_drain", exp_pc, 32'h30);

        // Redirect with two requests in flight and two queued entries
        chk_addr = 1'b0; chk_out = 1'b0;
        out_ready = 1'b0; mem_en = 1'b1;
        do_reset();
        tick();
        tick();
        mem_en = 1'b0;
        tick();
        tick();
        chk("pre_rd_valid", {31'b0, out_valid}, 32'd1);
        chk("pre_rd_req", {31'b0, imem_req}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; mem_en = 1'b1;
        #1;
        chk("rd_cycle_req", {31'b0, imem_req}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rd_valid", {31'b0, out_valid}, 32'd0);
        chk("rd_addr", imem_addr, 32'h100);
        chk("rd_credit_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("rd_kill1_req", {31'b0, imem_req}, 32'd1);
        chk("rd_kill1_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("rd_kill2_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("rd_first_valid", {31'b0, out_valid}, 32'd1);
        chk("rd_first_pc", out_pc, 32'h100);
        chk("rd_first_inst", out_inst, inst_of(32'h100));

        // Redirect coinciding with a response and a pop
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        chk("rv_pre_rvalid", {31'b0, imem_rvalid}, 32'd1);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rv_valid", {31'b0, out_valid}, 32'd0);
        chk("rv_addr", imem_addr, 32'h300);
        chk("rv_req", {31'b0, imem_req}, 32'd1);
        tick();
        chk("rv_valid_n1", {31'b0, out_valid}, 32'd0);
        tick();
        chk("rv_valid_n2", {31'b0, out_valid}, 32'd1);
        chk("rv_pc", out_pc, 32'h300);

        // Fetch address wraps at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_req", {31'b0, imem_req}, 32'd1);
        tick();
        chk("wrap_addr1", imem_addr, 32'h0);
        wait_valid(8);
        chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        tick();
        wait_valid(8);
        chk("wrap_pc1", out_pc, 32'h0);
        chk("wrap_inst1", out_inst, inst_of(32'h0));

        // Reset mid-stream with two outstanding requests
        mem_en = 1'b0;
        repeat (4) tick();
        chk("mid_req_blocked", {31'b0, imem_req}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_pc", out_pc, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        mem_en = 1'b1;
        pend.delete();
        pend.push_back(32'hDEAD_BEE0);
        imem_rvalid = 1'b1;
        imem_rdata  = INST_NOP;
        #1;
        chk("post_rst_req", {31'b0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        tick();
        chk("late_rsp_ignored", {31'b0, out_valid}, 32'd0);
        tick();
        chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("post_rst_pc", out_pc, 32'h0);
        chk("post_rst_inst", out_inst, inst_of(32'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
